nco_voice_scheduler: RTL and testbench
======================================

# nco_voice_scheduler

Polyphonic voice controller that time-shares a single NCO interpolation datapath between up to four voices. It accepts key on/off events and allocates them to voice slots, with optional stealing of the oldest voice. On every 48 kHz sample tick it advances each active voice's phase and sequences the shared datapath once per active voice. It sums the returned samples into one saturated mix sample for the I2S transmitter.

## Interface
- NUM_VOICES, 4: voice slots; legal values 1–4.
- master_clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- sample_clk_en  in  1  one-cycle 48 kHz tick.
- note_valid  in  1  key event present.
- note_ready  out  1  event accepted this cycle when valid && ready.
- note_on  in  1  1 = key pressed, 0 = key released.
- note_key  in  6  key id.
- note_inc  in  32  phase increment for note_on; ignored for note_off.
- dp_start  out  1  one-cycle request to the shared datapath.
- dp_phase  out  32  phase of the voice being rendered; held from dp_start until dp_done.
- dp_done  in  1  one-cycle pulse; dp_sample valid.
- dp_sample  in  16  unsigned offset-binary sample.
- mix_sample  out  16  unsigned offset-binary mix; silence is 16'h8000.
- mix_valid  out  1  one-cycle pulse when mix_sample updates.
- voices_active  out  NUM_VOICES  per-slot active flags.
- overrun  out  1  sticky flag; a tick arrived while a tick was already pending.

## Operation
- Per-slot state: active, key[5:0], inc[31:0], phase[31:0], age[7:0].
- FSM states: IDLE, ADVANCE, ISSUE, WAIT, OUTPUT.
- Tick capture: sample_clk_en sets tick_pend in any state.
  - If tick_pend is already set, set overrun.
  - tick_pend clears on entry to ADVANCE.
- IDLE:
  - note_ready = !tick_pend; note_ready is 0 in all other states.
  - If tick_pend, go to ADVANCE; otherwise process an accepted note event.
- note_on, key matches an active slot: retrigger that slot.
  - phase=0, inc=note_inc, age=0.
  - Age of all other active slots increments, saturating at 255.
- note_on, no key match: allocate the lowest-index inactive slot with the same updates.
  - If no slot is inactive, apply the Configuration rule.
- note_off: clear active on a matching slot. No match: event is consumed and ignored.
- ADVANCE (1 cycle): phase += inc, mod 2^32, for all active slots. Clear the accumulator and set the voice index to 0.
- ISSUE: skip inactive slots.
  - Active slot: drive dp_phase=phase[v] and pulse dp_start, then go to WAIT.
  - After the last slot, go to OUTPUT.
- WAIT: on dp_done, add signed(dp_sample ^ 16'h8000) to the 18-bit signed accumulator, advance v, and return to ISSUE. There is no timeout.
- OUTPUT: saturate the accumulator to [-32768, 32767], XOR with 16'h8000 into mix_sample, pulse mix_valid, and return to IDLE.
  - With zero active voices, the result is 16'h8000.
- Reset values:
  - note_ready=0, dp_start=0, dp_phase=0, mix_sample=16'h8000, mix_valid=0, voices_active=0, overrun=0.
  - All slot state and tick_pend are 0; FSM is in IDLE.
  - note_ready rises the cycle after reset release.
  - Reset mid-render drops the render; no mix_valid is emitted.

## Timing
- Event acceptance: 1 cycle. The slot update is visible on voices_active the next cycle.
- Tick to first dp_start: 3 cycles (capture, IDLE→ADVANCE, ADVANCE→ISSUE).
- Per active voice: 1 ISSUE cycle plus datapath latency L plus 1 cycle.
  - With a 4-cycle datapath and 4 voices: tick→mix_valid is 3 + 4×(L+2) + 1 cycles.
- A tick coinciding with a note handshake in IDLE: the note is not accepted (ready already 0 due to the pending tick).
- A tick in the same cycle as the IDLE→ADVANCE transition sets overrun.
- dp_done outside WAIT is ignored.

## Configuration
- VOICE_STEAL_EN defined: note_on with no free slot steals the slot with the largest age (ties: lowest index).
  - The stolen slot gets phase=0, inc=note_inc, age=0.
- VOICE_STEAL_EN undefined: such a note_on is consumed and discarded; slots are unchanged.

## Test plan
- Reset, then one tick with no notes -> dp_start never pulses; mix_valid pulses 4 cycles after the tick with mix_sample=16'h8000.
- note_on key 5, inc=32'h0100_0000, then a tick; stub datapath returns dp_sample=dp_phase[31:16] -> dp_phase=32'h0100_0000; mix_sample=16'h0100.
- Four voices, each returning 16'hFFFF -> sum 4×32767 saturates; mix_sample=16'hFFFF. Same with 16'h0000 -> 16'h0000.
- Five note_on events (keys 1–5), then note_off key 9:
  - With VOICE_STEAL_EN: key 5 occupies slot 0.
  - Without it: key 5 is dropped.
  - Either way, voices_active=4'b1111 and note_off key 9 changes nothing.
- Datapath stalled with 3 ticks arriving -> overrun=1 and stays 1; the render completes normally after dp_done resumes.
- Assert rst in WAIT -> all outputs return to reset values asynchronously; no mix_valid is emitted.

Source files
------------

// File: rtl/nco_voice_scheduler_if.sv
// nco_voice_scheduler_if: note-event handshake, shared NCO datapath link and mix output of the voice scheduler.
interface nco_voice_scheduler_if #(parameter int NUM_VOICES = 4);
    logic                  note_valid;
    logic                  note_ready;
    logic                  note_on;
    logic [5:0]            note_key;
    logic [31:0]           note_inc;
    logic                  dp_start;
    logic [31:0]           dp_phase;
    logic                  dp_done;
    logic [15:0]           dp_sample;
    logic [15:0]           mix_sample;
    logic                  mix_valid;
    logic [NUM_VOICES-1:0] voices_active;
    logic                  overrun;
    modport slave (
        input  note_valid, note_on, note_key, note_inc, dp_done, dp_sample,
        output note_ready, dp_start, dp_phase, mix_sample, mix_valid, voices_active, overrun
    );
    modport master (
        output note_valid, note_on, note_key, note_inc, dp_done, dp_sample,
        input  note_ready, dp_start, dp_phase, mix_sample, mix_valid, voices_active, overrun
    );
endinterface

// File: rtl/nco_voice_scheduler.sv
// nco_voice_scheduler: allocates key events to voice slots and time-shares one NCO datapath per sample tick.
// Define VOICE_STEAL_EN to let a note_on with no free slot take over the oldest voice.
module nco_voice_scheduler #(
    parameter int NUM_VOICES = 4
) (
    input  logic                  master_clk,
    input  logic                  rst,
    input  logic                  sample_clk_en,
    nco_voice_scheduler_if.slave  bus
);
`ifdef VOICE_STEAL_EN
    localparam bit STEAL = 1'b1;
`else
    localparam bit STEAL = 1'b0;
`endif
    typedef enum logic [2:0] {IDLE, ADVANCE, ISSUE, WAIT, OUTPUT} state_t;
    state_t state, state_n;
    logic [NUM_VOICES-1:0] active;
    logic [5:0]            key   [NUM_VOICES];
    logic [31:0]           inc   [NUM_VOICES];
    logic [31:0]           phase [NUM_VOICES];
    logic [7:0]            age   [NUM_VOICES];
    logic                  tick_pend, overrun, rdy_en;
    logic [2:0]            v, nv, mi, fi, oi, tgt;
    logic                  found, match, free;
    logic [7:0]            best;
    logic [31:0]           issue_phase, dp_phase_q;
    logic signed [17:0]    acc;
    logic [15:0]           mix_q, sat, mix, s_off;
    logic                  note_ready, accept, do_on, do_off;
    // Slot searches: next active slot at or after v, key match, lowest free slot, oldest slot.
    always_comb begin
        found = 1'b0;
        nv = 3'd0;
        issue_phase = 32'd0;
        match = 1'b0;
        mi = 3'd0;
        free = 1'b0;
        fi = 3'd0;
        oi = 3'd0;
        best = age[0];
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (active[i] && 3'(i) >= v) begin
                found = 1'b1;
                nv = 3'(i);
                issue_phase = phase[i];
            end
            if (active[i] && key[i] == bus.note_key) begin
                match = 1'b1;
                mi = 3'(i);
            end
            if (!active[i]) begin
                free = 1'b1;
                fi = 3'(i);
            end
        end
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (age[i] > best) begin
                best = age[i];
                oi = 3'(i);
            end
        end
    end
    assign tgt        = match ? mi : free ? fi : oi;
    assign note_ready = rdy_en && state == IDLE && !tick_pend;
    assign accept     = bus.note_valid && note_ready;
    assign do_on      = accept && bus.note_on && (match || free || STEAL);
    assign do_off     = accept && !bus.note_on && match;
    assign s_off      = bus.dp_sample ^ 16'h8000;
    assign sat        = acc > 18'sd32767 ? 16'h7FFF : acc < -18'sd32768 ? 16'h8000 : acc[15:0];
    assign mix        = sat ^ 16'h8000;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = tick_pend ? ADVANCE : IDLE;
            ADVANCE: state_n = ISSUE;
            ISSUE:   state_n = found ? WAIT : OUTPUT;
            WAIT:    state_n = bus.dp_done ? ISSUE : WAIT;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end
    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            rdy_en     <= 1'b0;
            tick_pend  <= 1'b0;
            overrun    <= 1'b0;
            v          <= 3'd0;
            acc        <= 18'sd0;
            dp_phase_q <= 32'd0;
            mix_q      <= 16'h8000;
            active     <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                key[i]   <= 6'd0;
                inc[i]   <= 32'd0;
                phase[i] <= 32'd0;
                age[i]   <= 8'd0;
            end
        end else begin
            rdy_en    <= 1'b1;
            tick_pend <= sample_clk_en | (tick_pend & (state != IDLE));
            overrun   <= overrun | (sample_clk_en & tick_pend);
            if (state == ADVANCE) begin
                acc <= 18'sd0;
                v   <= 3'd0;
            end
            if (state == ISSUE && found) begin
                v          <= nv;
                dp_phase_q <= issue_phase;
            end
            if (state == WAIT && bus.dp_done) begin
                acc <= acc + signed'({{2{s_off[15]}}, s_off});
                v   <= v + 3'd1;
            end
            if (state == OUTPUT) mix_q <= mix;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (state == ADVANCE && active[i]) begin
                    phase[i] <= phase[i] + inc[i];
                end else if (do_on && 3'(i) == tgt) begin
                    active[i] <= 1'b1;
                    key[i]    <= bus.note_key;
                    inc[i]    <= bus.note_inc;
                    phase[i]  <= 32'd0;
                    age[i]    <= 8'd0;
                end else if (do_on && active[i]) begin
                    age[i] <= age[i] + {7'd0, age[i] != 8'hFF};
                end
                if (do_off && 3'(i) == mi) active[i] <= 1'b0;
            end
        end
    end
    assign bus.note_ready    = note_ready;
    assign bus.dp_start      = state == ISSUE && found;
    assign bus.dp_phase      = (state == ISSUE && found) ? issue_phase : dp_phase_q;
    assign bus.mix_valid     = state == OUTPUT;
    assign bus.mix_sample    = state == OUTPUT ? mix : mix_q;
    assign bus.voices_active = active;
    assign bus.overrun       = overrun;
endmodule

// File: tb/tb_nco_voice_scheduler.sv
// tb_nco_voice_scheduler: directed vectors against a fixed-latency datapath stub for nco_voice_scheduler.
module tb_nco_voice_scheduler;
    localparam int L = 4;
    logic master_clk = 1'b0;
    logic rst = 1'b0;
    logic sample_clk_en = 1'b0;
    nco_voice_scheduler_if #(.NUM_VOICES(4)) bus ();
    nco_voice_scheduler #(.NUM_VOICES(4)) dut (
        .master_clk    (master_clk),
        .rst           (rst),
        .sample_clk_en (sample_clk_en),
        .bus           (bus)
    );
    always #5 master_clk = ~master_clk;
    typedef struct {
        logic        on;
        logic [5:0]  key;
        logic [31:0] inc;
        logic [3:0]  exp_act;
    } note_vec_t;
    typedef struct {
        logic [15:0] smp;
        logic [15:0] exp_mix;
    } mix_vec_t;
    note_vec_t   nv_tab [9];
    mix_vec_t    mv_tab [5];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          dp_cnt = 0;
    int          mix_cnt = 0;
    int          mix_cyc = 0;
    int          start_cnt = 0;
    logic [15:0] last_mix = 16'h0;
    logic [31:0] first_phase = 32'h0;
    logic        stall = 1'b0;
    logic        use_phase = 1'b1;
    logic [15:0] smp_const = 16'h0;
    int          lat;
    always @(posedge master_clk) cyc++;
    // Datapath stub: dp_done lands L+1 cycles after dp_start; stall holds it back.
    always @(negedge master_clk) begin
        bus.dp_done = 1'b0;
        if (!rst) begin
            dp_cnt = 0;
        end else begin
            if (dp_cnt > 0 && !(dp_cnt == 1 && stall)) begin
                dp_cnt--;
                if (dp_cnt == 0) bus.dp_done = 1'b1;
            end
            if (bus.dp_start) begin
                dp_cnt = L + 1;
                bus.dp_sample = use_phase ? bus.dp_phase[31:16] : smp_const;
                if (start_cnt == 0) first_phase = bus.dp_phase;
                start_cnt++;
            end
        end
        if (bus.mix_valid) begin
            mix_cnt++;
            mix_cyc = cyc;
            last_mix = bus.mix_sample;
        end
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic do_reset();
        @(negedge master_clk);
        rst = 1'b0;
        repeat (2) @(negedge master_clk);
        rst = 1'b1;
        @(negedge master_clk);
    endtask
    task automatic send_note(input logic on, input logic [5:0] k, input logic [31:0] inc);
        int n = 0;
        while (!bus.note_ready && n < 50) begin
            @(negedge master_clk);
            n++;
        end
        if (!bus.note_ready) begin
            checks++;
            errors++;
            $display("FAIL note_ready_timeout: got 0 expected 1");
        end
        bus.note_valid = 1'b1;
        bus.note_on = on;
        bus.note_key = k;
        bus.note_inc = inc;
        @(posedge master_clk);
        @(negedge master_clk);
        bus.note_valid = 1'b0;
    endtask
    task automatic pulse_tick();
        sample_clk_en = 1'b1;
        @(negedge master_clk);
        sample_clk_en = 1'b0;
    endtask
    task automatic tick_render(output int l);
        int n = 0;
        int t0;
        mix_cnt = 0;
        start_cnt = 0;
        t0 = cyc;
        pulse_tick();
        while (mix_cnt == 0 && n < 400) begin
            @(negedge master_clk);
            n++;
        end
        if (mix_cnt == 0) begin
            checks++;
            errors++;
            $display("FAIL render_timeout: got no mix_valid expected one");
        end
        l = mix_cyc - t0;
    endtask
    initial begin
        nv_tab[0] = '{1'b1, 6'd1, 32'h0010_0000, 4'b0001};
        nv_tab[1] = '{1'b1, 6'd2, 32'h0020_0000, 4'b0011};
        nv_tab[2] = '{1'b1, 6'd3, 32'h0030_0000, 4'b0111};
        nv_tab[3] = '{1'b1, 6'd4, 32'h0040_0000, 4'b1111};
        nv_tab[4] = '{1'b1, 6'd5, 32'h0050_0000, 4'b1111};
        nv_tab[5] = '{1'b0, 6'd9, 32'h0,         4'b1111};
`ifdef VOICE_STEAL_EN
        nv_tab[6] = '{1'b0, 6'd5, 32'h0,         4'b1110};
`else
        nv_tab[6] = '{1'b0, 6'd5, 32'h0,         4'b1111};
`endif
        nv_tab[7] = '{1'b0, 6'd1, 32'h0,         4'b1110};
        nv_tab[8] = '{1'b1, 6'd7, 32'h0070_0000, 4'b1111};
        mv_tab[0] = '{16'hFFFF, 16'hFFFF};
        mv_tab[1] = '{16'h0000, 16'h0000};
        mv_tab[2] = '{16'hA000, 16'hFFFF};
        mv_tab[3] = '{16'h7000, 16'h4000};
        mv_tab[4] = '{16'h9000, 16'hC000};
        bus.note_valid = 1'b0;
        bus.note_on = 1'b0;
        bus.note_key = 6'd0;
        bus.note_inc = 32'd0;
        repeat (3) @(negedge master_clk);
        check("rst_note_ready", 32'(bus.note_ready), 32'd0);
        check("rst_dp_start", 32'(bus.dp_start), 32'd0);
        check("rst_dp_phase", bus.dp_phase, 32'd0);
        check("rst_mix_sample", 32'(bus.mix_sample), 32'h8000);
        check("rst_mix_valid", 32'(bus.mix_valid), 32'd0);
        check("rst_voices", 32'(bus.voices_active), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        rst = 1'b1;
        #1;
        check("ready_at_release", 32'(bus.note_ready), 32'd0);
        @(negedge master_clk);
        check("ready_after_release", 32'(bus.note_ready), 32'd1);
        tick_render(lat);
        check("empty_latency", 32'(lat), 32'd4);
        check("empty_mix", 32'(last_mix), 32'h8000);
        check("empty_no_start", 32'(start_cnt), 32'd0);
        send_note(1'b1, 6'd5, 32'h0100_0000);
        check("one_voice_active", 32'(bus.voices_active), 32'b0001);
        tick_render(lat);
        check("one_phase", first_phase, 32'h0100_0000);
        check("one_mix", 32'(last_mix), 32'h0100);
        check("one_latency", 32'(lat), 32'(3 + (L + 2) + 1));
        tick_render(lat);
        check("second_phase", first_phase, 32'h0200_0000);
        check("second_mix", 32'(last_mix), 32'h0200);
        send_note(1'b1, 6'd5, 32'h0030_0000);
        check("retrig_active", 32'(bus.voices_active), 32'b0001);
        tick_render(lat);
        check("retrig_phase", first_phase, 32'h0030_0000);
        check("retrig_mix", 32'(last_mix), 32'h0030);
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send_note(nv_tab[i].on, nv_tab[i].key, nv_tab[i].inc);
            check($sformatf("note_tab[%0d]", i), 32'(bus.voices_active), 32'(nv_tab[i].exp_act));
        end
        use_phase = 1'b0;
        for (int i = 0; i < 5; i++) begin
            smp_const = mv_tab[i].smp;
            tick_render(lat);
            check($sformatf("mix_tab[%0d]", i), 32'(last_mix), 32'(mv_tab[i].exp_mix));
            check($sformatf("mix_lat[%0d]", i), 32'(lat), 32'(3 + 4 * (L + 2) + 1));
            check($sformatf("mix_starts[%0d]", i), 32'(start_cnt), 32'd4);
        end
        stall = 1'b1;
        mix_cnt = 0;
        pulse_tick();
        repeat (10) @(negedge master_clk);
        check("ovr_after_one", 32'(bus.overrun), 32'd0);
        pulse_tick();
        repeat (5) @(negedge master_clk);
        check("ovr_after_two", 32'(bus.overrun), 32'd0);
        pulse_tick();
        @(negedge master_clk);
        check("ovr_after_three", 32'(bus.overrun), 32'd1);
        stall = 1'b0;
        for (int n = 0; n < 200 && mix_cnt < 2; n++) @(negedge master_clk);
        repeat (40) @(negedge master_clk);
        check("ovr_renders", 32'(mix_cnt), 32'd2);
        check("ovr_mix", 32'(last_mix), 32'hC000);
        check("ovr_sticky", 32'(bus.overrun), 32'd1);
        stall = 1'b1;
        pulse_tick();
        repeat (8) @(negedge master_clk);
        check("wait_pre_mix", 32'(bus.mix_sample), 32'hC000);
        #2;
        rst = 1'b0;
        #1;
        check("wrst_note_ready", 32'(bus.note_ready), 32'd0);
        check("wrst_dp_start", 32'(bus.dp_start), 32'd0);
        check("wrst_dp_phase", bus.dp_phase, 32'd0);
        check("wrst_mix_sample", 32'(bus.mix_sample), 32'h8000);
        check("wrst_mix_valid", 32'(bus.mix_valid), 32'd0);
        check("wrst_voices", 32'(bus.voices_active), 32'd0);
        check("wrst_overrun", 32'(bus.overrun), 32'd0);
        stall = 1'b0;
        @(negedge master_clk);
        rst = 1'b1;
        mix_cnt = 0;
        repeat (40) @(negedge master_clk);
        check("wrst_no_mix", 32'(mix_cnt), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
